// File: rtl/hv_bundler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hv_bundler
// Purpose  : Reads NUM_CH consecutive hypervectors from the upstream FIFO and
//            bundles them into one hypervector by bitwise majority vote. The
//            result goes downstream over a valid/ready handshake.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            fifo_empty        - FIFO empty flag
//            fifo_rd_en        - FIFO read strobe (combinational)
//            fifo_dout         - FIFO registered read data (valid 1 cycle
//                                after fifo_rd_en)
//            hv_out, hv_valid  - bundled hypervector and its valid flag
//            hv_ready          - downstream accept
//            busy              - a bundle is in progress or being held
// Revision : 1.0 - initial release
// ============================================================================
module hv_bundler #(
    parameter int DIM       = 8,
    parameter int NUM_CH    = 3,
    parameter int CNT_WIDTH = $clog2(NUM_CH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    input  logic [0:DIM-1] fifo_dout,
    output logic [0:DIM-1] hv_out,
    output logic           hv_valid,
    input  logic           hv_ready,
    output logic           busy
);

    localparam logic                 c_S_ACC      = 1'b0;
    localparam logic                 c_S_OUT      = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_NUM_CH     = CNT_WIDTH'(NUM_CH);
    localparam logic [CNT_WIDTH:0]   c_NUM_CH_EXT = (CNT_WIDTH + 1)'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] c_ONE        = CNT_WIDTH'(1);

    logic                            r_state;
    logic [CNT_WIDTH-1:0]            r_rd_cnt;
    logic [CNT_WIDTH-1:0]            r_acc_cnt;
    logic                            r_rd_pending;
    logic [DIM-1:0][CNT_WIDTH-1:0]   r_cnt;
    logic [0:DIM-1]                  r_hv_out;
    logic                            r_hv_valid;

    logic                            w_rd_en;
    logic [CNT_WIDTH-1:0]            w_acc_nxt;
    logic [DIM-1:0][CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [0:DIM-1]                  w_majority;

    // The FIFO has no underflow protection, so the empty flag gates the read.
    assign w_rd_en   = (r_state == c_S_ACC) && !fifo_empty && (r_rd_cnt < c_NUM_CH);
    assign w_acc_nxt = r_acc_cnt + c_ONE;

    // Per-bit counters including the sample arriving this cycle, so the
    // final vote needs no extra cycle after the last sample lands.
    // 2*count > NUM_CH: a tie on even NUM_CH resolves to 0.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_bit
            assign w_cnt_nxt[gi]  = r_cnt[gi] + CNT_WIDTH'(fifo_dout[gi]);
            assign w_majority[gi] = ({w_cnt_nxt[gi], 1'b0} > c_NUM_CH_EXT);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_ACC;
            r_rd_cnt     <= '0;
            r_acc_cnt    <= '0;
            r_rd_pending <= 1'b0;
            r_cnt        <= '0;
            r_hv_out     <= '0;
            r_hv_valid   <= 1'b0;
        end else begin
            // fifo_dout is valid exactly one cycle after the strobe.
            r_rd_pending <= w_rd_en;
            if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + c_ONE;
            end
            case (r_state)
                c_S_ACC: begin
                    if (r_rd_pending) begin
                        r_cnt     <= w_cnt_nxt;
                        r_acc_cnt <= w_acc_nxt;
                        if (w_acc_nxt == c_NUM_CH) begin
                            r_hv_out   <= w_majority;
                            r_hv_valid <= 1'b1;
                            r_state    <= c_S_OUT;
                        end
                    end
                end
                c_S_OUT: begin
                    // hv_out is deliberately left holding the last bundle.
                    if (hv_ready) begin
                        r_hv_valid <= 1'b0;
                        r_cnt      <= '0;
                        r_rd_cnt   <= '0;
                        r_acc_cnt  <= '0;
                        r_state    <= c_S_ACC;
                    end
                end
                default: begin
                    r_state <= c_S_ACC;
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign hv_out     = r_hv_out;
    assign hv_valid   = r_hv_valid;
    assign busy       = (r_rd_cnt != '0) || r_hv_valid;

endmodule
`default_nettype wire

// File: tb/tb_hv_bundler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hv_bundler
// Purpose  : Self-checking bench for hv_bundler. Two instances (NUM_CH=3 and
//            NUM_CH=4) each read from a small FIFO model; a majority-vote
//            reference model predicts every bundle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hv_bundler;

    localparam int DIM = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     rd_en, empty, vld, rdy, busy;
    logic [0:DIM-1] dout [2];
    logic [0:DIM-1] hvo  [2];

    logic [7:0]     mem [2][64];
    int             wp [2];
    int             rp [2];

    logic [7:0]     pend0[$], pend1[$], exp0[$], exp1[$];

    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;

    // monitor state
    logic [1:0]     pv, pr;
    logic [0:DIM-1] ph [2];
    int             nreads0 = 0, nbund0 = 0, first_rd0 = 0, rise0 = -1;
    logic [7:0]     last0 = 8'h00, last1 = 8'h00;
    bit             spacing_on = 1'b0, lat_on = 1'b0, busy_win = 1'b0;

    always #5 clk = ~clk;

    hv_bundler #(.DIM(DIM), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_rd_en(rd_en[0]),
        .fifo_dout(dout[0]), .hv_out(hvo[0]), .hv_valid(vld[0]),
        .hv_ready(rdy[0]), .busy(busy[0])
    );

    hv_bundler #(.DIM(DIM), .NUM_CH(4)) u_dut4 (
        .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_rd_en(rd_en[1]),
        .fifo_dout(dout[1]), .hv_out(hvo[1]), .hv_valid(vld[1]),
        .hv_ready(rdy[1]), .busy(busy[1])
    );

    task automatic check_eq(input string tag, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Majority of n words: a bit is 1 when strictly more than half are 1.
    function automatic logic [7:0] majority(input logic [7:0] w [$], input int n);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = 0;
            for (int j = 0; j < n; j++) ones += int'(w[j][b]);
            r[b] = (2 * ones > n);
        end
        return r;
    endfunction

    // FIFO models: registered dout, flushed by the shared reset.
    always_comb begin
        for (int k = 0; k < 2; k++) empty[k] = (wp[k] == rp[k]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rp[k] <= wp[k];
            end else if (rd_en[k]) begin
                dout[k] <= mem[k][rp[k] % 64];
                rp[k]   <= rp[k] + 1;
            end
        end
    end

    task automatic push(input int k, input logic [7:0] w);
        mem[k][wp[k] % 64] = w;
        wp[k] = wp[k] + 1;
        if (k == 0) begin
            pend0.push_back(w);
            if (pend0.size() == 3) begin
                exp0.push_back(majority(pend0, 3));
                pend0.delete();
            end
        end else begin
            pend1.push_back(w);
            if (pend1.size() == 4) begin
                exp1.push_back(majority(pend1, 4));
                pend1.delete();
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || vld != 2'b00) && n < 300) begin
            tick(1);
            n++;
        end
        check_eq("idle_timeout", int'(n >= 300), 0);
    endtask

    task automatic wait_valid0();
        int n;
        n = 0;
        while (!vld[0] && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("valid_timeout", int'(n >= 100), 0);
    endtask

    // Protocol and data monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pv <= 2'b00;
            pr <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en[k]) begin
                    check_eq("rd_while_empty", int'(empty[k]), 0);
                    check_eq("rd_while_valid", int'(vld[k]), 0);
                end
                if (vld[k] && pv[k] && !pr[k])
                    check_eq("hold_hv_out", int'(hvo[k]), int'(ph[k]));
                if (vld[k] && rdy[k]) begin
                    if (k == 0) begin
                        if (exp0.size() == 0) check_eq("unexpected_bundle0", int'(hvo[0]), -1);
                        else check_eq("bundle0", int'(hvo[0]), int'(exp0.pop_front()));
                    end else begin
                        if (exp1.size() == 0) check_eq("unexpected_bundle1", int'(hvo[1]), -1);
                        else check_eq("bundle1", int'(hvo[1]), int'(exp1.pop_front()));
                    end
                end
            end
            if (busy_win) check_eq("busy_stall", int'(busy[0]), 1);
            pv    <= vld;
            pr    <= rdy;
            ph[0] <= hvo[0];
            ph[1] <= hvo[1];
            if (rd_en[0]) begin
                nreads0 <= nreads0 + 1;
                if (!busy[0]) first_rd0 <= cyc;
            end
            if (vld[0] && rdy[0]) begin
                nbund0 <= nbund0 + 1;
                last0  <= hvo[0];
            end
            if (vld[1] && rdy[1]) last1 <= hvo[1];
            if (vld[0] && !pv[0]) begin
                if (spacing_on && rise0 >= 0) check_eq("spacing", cyc - rise0, 5);
                if (lat_on) check_eq("latency", cyc - first_rd0, 4);
                rise0 <= cyc;
            end
            if (!spacing_on) rise0 <= -1;
        end
    end

    initial begin
        int n0, pushed;
        rst = 1'b1;
        rdy = 2'b11;
        tick(3);
        check_eq("rst_hv_valid", int'(vld), 0);
        check_eq("rst_hv_out", int'(hvo[0]), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_rd_en", int'(rd_en), 0);
        rst = 1'b0;
        tick(2);

        // 1: basic bundle, continuous FIFO
        lat_on = 1'b1;
        n0 = nreads0;
        push(0, 8'hF0); push(0, 8'hCC); push(0, 8'hAA);
        wait_idle();
        tick(2);
        check_eq("t1_reads", nreads0 - n0, 3);
        check_eq("t1_hv_out", int'(last0), 'hE8);
        lat_on = 1'b0;

        // 2: even NUM_CH, ties resolve to 0
        push(1, 8'hFF); push(1, 8'h0F); push(1, 8'h00); push(1, 8'h03);
        wait_idle();
        tick(1);
        check_eq("t2_tie", int'(last1), 'h03);

        // 3: backpressure
        rdy[0] = 1'b0;
        push(0, 8'hF0); push(0, 8'hCC); push(0, 8'hAA);
        push(0, 8'h01); push(0, 8'h01); push(0, 8'h00);
        wait_valid0();
        n0 = nreads0;
        tick(10);
        check_eq("t3_held_out", int'(hvo[0]), 'hE8);
        check_eq("t3_held_valid", int'(vld[0]), 1);
        check_eq("t3_no_reads", nreads0 - n0, 0);
        rdy[0] = 1'b1;
        wait_idle();
        tick(1);
        check_eq("t3_second", int'(last0), 'h01);

        // 4: empty stalls mid-bundle
        push(0, 8'hF0);
        tick(1);
        busy_win = 1'b1;
        tick(5);
        push(0, 8'hCC);
        tick(3);
        push(0, 8'hAA);
        wait_valid0();
        busy_win = 1'b0;
        wait_idle();
        tick(1);
        check_eq("t4_hv_out", int'(last0), 'hE8);

        // 5: reset while the second sample is still in flight
        push(0, 8'hF0); push(0, 8'hCC);
        tick(2);
        rst = 1'b1;
        pend0.delete();
        tick(1);
        rst = 1'b0;
        check_eq("t5_valid", int'(vld[0]), 0);
        check_eq("t5_hv_out", int'(hvo[0]), 0);
        check_eq("t5_busy", int'(busy[0]), 0);
        check_eq("t5_rd_en", int'(rd_en[0]), 0);
        push(0, 8'h0F); push(0, 8'h0F); push(0, 8'h00);
        wait_idle();
        tick(1);
        check_eq("t5_hv_out_after", int'(last0), 'h0F);

        // 6: streaming random words, ready tied high
        spacing_on = 1'b1;
        lat_on     = 1'b1;
        n0 = nbund0;
        for (int i = 0; i < 30; i++) push(0, 8'($urandom));
        wait_idle();
        tick(1);
        check_eq("t6_bundles", nbund0 - n0, 10);
        spacing_on = 1'b0;
        lat_on     = 1'b0;

        // 7: random push gaps and random backpressure
        pushed = 0;
        for (int c = 0; c < 400 && pushed < 15; c++) begin
            rdy[0] = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                push(0, 8'($urandom));
                pushed++;
            end
            tick(1);
        end
        check_eq("t7_pushed", pushed, 15);
        rdy[0] = 1'b1;
        wait_idle();
        check_eq("t7_no_partial", pend0.size(), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
